// File: rtl/dma_regs_pkg.sv
// Shared definitions for the DMA address/count register bank.
//
// Contents:
//   - default widths and derived byte counts
//   - read_src_t: which register family drives the CPU read mux
//   - byte_count(): bytes in a register of a given width
//   - bp_width(): width of the shared byte pointer
//   - lowest_one_hot(): keeps only the lowest set bit of a strobe vector
//
// Optional feature macro used by the files that import this package:
//   DMA_BASE_READBACK_EN (base registers become readable).
package dma_regs_pkg;

  // Upper bound on channel count. lowest_one_hot() works on this width.
  localparam int MAX_CHANNELS = 32;

  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_ADDR_WIDTH  = 16;
  localparam int DEFAULT_COUNT_WIDTH = 16;
  localparam int DEFAULT_ADDR_BYTES  = DEFAULT_ADDR_WIDTH / 8;
  localparam int DEFAULT_COUNT_BYTES = DEFAULT_COUNT_WIDTH / 8;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_CUR_ADDR,
    SRC_CUR_COUNT,
    SRC_BASE_ADDR,
    SRC_BASE_COUNT
  } read_src_t;

  function automatic int byte_count(input int width);
    return width / 8;
  endfunction

  // A single-byte register still gets a 1-bit pointer so the port
  // never collapses to zero width.
  function automatic int bp_width(input int addr_width, input int count_width);
    int bytes;
    bytes = ((addr_width > count_width) ? addr_width : count_width) / 8;
    return (bytes <= 2) ? 1 : $clog2(bytes);
  endfunction

  // v & -v isolates the lowest set bit.
  function automatic logic [MAX_CHANNELS-1:0] lowest_one_hot(
    input logic [MAX_CHANNELS-1:0] v
  );
    return v & (~v + MAX_CHANNELS'(1));
  endfunction

endpackage

// File: rtl/dma_address_count_bank_if.sv
// Signal bundle between the bus/command decoder plus transfer timing logic
// (master) and the DMA address/count register bank (slave).
//
// Access semantics: every strobe and next_word is a single-cycle qualifier
// sampled at the rising clock edge. The bank never back-pressures, so the
// ready side is implicitly always 1. A strobe held high for N edges is N
// accesses. Read data, underflow and transfer_address are combinational
// and valid in the same cycle as the strobes and select that produce them.
//
// With DMA_BASE_READBACK_EN defined, read_base_address and
// read_base_word_count are added (base-register read strobes).
interface dma_address_count_bank_if #(
  parameter int CHANNELS    = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
);
  logic [7:0]            internal_data_bus;
  logic [7:0]            read_address_or_count;
  logic [CHANNELS-1:0]   write_base_and_current_address;
  logic [CHANNELS-1:0]   write_base_and_current_word_count;
  logic [CHANNELS-1:0]   read_current_address;
  logic [CHANNELS-1:0]   read_current_word_count;
`ifdef DMA_BASE_READBACK_EN
  logic [CHANNELS-1:0]   read_base_address;
  logic [CHANNELS-1:0]   read_base_word_count;
`endif
  logic                  clear_byte_pointer;
  logic                  master_clear;
  logic [CHANNELS-1:0]   transfer_register_select;
  logic                  initialize_current_register;
  logic                  decrement_address_config;
  logic [CHANNELS-1:0]   auto_initialize_config;
  logic                  next_word;
  logic                  underflow;
  logic [ADDR_WIDTH-1:0] transfer_address;

  modport master (
    output internal_data_bus,
    output write_base_and_current_address,
    output write_base_and_current_word_count,
    output read_current_address,
    output read_current_word_count,
`ifdef DMA_BASE_READBACK_EN
    output read_base_address,
    output read_base_word_count,
`endif
    output clear_byte_pointer,
    output master_clear,
    output transfer_register_select,
    output initialize_current_register,
    output decrement_address_config,
    output auto_initialize_config,
    output next_word,
    input  read_address_or_count,
    input  underflow,
    input  transfer_address
  );

  modport slave (
    input  internal_data_bus,
    input  write_base_and_current_address,
    input  write_base_and_current_word_count,
    input  read_current_address,
    input  read_current_word_count,
`ifdef DMA_BASE_READBACK_EN
    input  read_base_address,
    input  read_base_word_count,
`endif
    input  clear_byte_pointer,
    input  master_clear,
    input  transfer_register_select,
    input  initialize_current_register,
    input  decrement_address_config,
    input  auto_initialize_config,
    input  next_word,
    output read_address_or_count,
    output underflow,
    output transfer_address
  );

endinterface

// File: rtl/dma_channel_regs.sv
// One DMA channel's base/current address and base/current word-count
// registers, with byte-wise CPU load and per-word step logic.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   master_clear          synchronous clear of all four registers
//   write_address         load byte byte_pointer of base+current address
//   write_count           load byte byte_pointer of base+current count
//   byte_pointer, data    shared byte pointer and CPU write byte
//   initialize            current <- base
//   step                  one word transferred on this channel
//   decrement             address steps down when 1, up when 0
//   auto_initialize       reload from base instead of wrapping the count
//   current_address, current_count   current registers
//   base_address, base_count         only with DMA_BASE_READBACK_EN
//
// Priority, highest first: master_clear, CPU write, initialize, step.
module dma_channel_regs
  import dma_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int BP_WIDTH    = bp_width(DEFAULT_ADDR_WIDTH, DEFAULT_COUNT_WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   master_clear,
  input  logic                   write_address,
  input  logic                   write_count,
  input  logic [BP_WIDTH-1:0]    byte_pointer,
  input  logic [7:0]             data,
  input  logic                   initialize,
  input  logic                   step,
  input  logic                   decrement,
  input  logic                   auto_initialize,
`ifdef DMA_BASE_READBACK_EN
  output logic [ADDR_WIDTH-1:0]  base_address,
  output logic [COUNT_WIDTH-1:0] base_count,
`endif
  output logic [ADDR_WIDTH-1:0]  current_address,
  output logic [COUNT_WIDTH-1:0] current_count
);

  localparam int ADDR_BYTES  = byte_count(ADDR_WIDTH);
  localparam int COUNT_BYTES = byte_count(COUNT_WIDTH);

`ifndef DMA_BASE_READBACK_EN
  logic [ADDR_WIDTH-1:0]  base_address;
  logic [COUNT_WIDTH-1:0] base_count;
`endif

  // A step on an exhausted count either wraps or restarts the block.
  logic reload;
  assign reload = step & auto_initialize & (current_count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_address    <= '0;
      current_address <= '0;
      base_count      <= '0;
      current_count   <= '0;
    end else if (master_clear) begin
      base_address    <= '0;
      current_address <= '0;
      base_count      <= '0;
      current_count   <= '0;
    end else if (write_address || write_count) begin
      // A pointer beyond this register's width (narrower of the two
      // register kinds) selects no byte.
      for (int b = 0; b < ADDR_BYTES; b++) begin
        if (write_address && int'(byte_pointer) == b) begin
          base_address[b*8 +: 8]    <= data;
          current_address[b*8 +: 8] <= data;
        end
      end
      for (int b = 0; b < COUNT_BYTES; b++) begin
        if (write_count && int'(byte_pointer) == b) begin
          base_count[b*8 +: 8]    <= data;
          current_count[b*8 +: 8] <= data;
        end
      end
    end else if (initialize || reload) begin
      current_address <= base_address;
      current_count   <= base_count;
    end else if (step) begin
      current_address <= decrement ? current_address - ADDR_WIDTH'(1)
                                   : current_address + ADDR_WIDTH'(1);
      current_count   <= current_count - COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dma_address_count_bank.sv
// Base/current address and word-count register bank for a multi-channel
// DMA datapath. The CPU reaches the registers byte-serially through one
// shared byte pointer; the transfer engine steps the selected channel with
// next_word pulses.
//
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   bus            dma_address_count_bank_if.slave: CPU data/strobes,
//                  byte-pointer clear, master clear, channel select,
//                  initialize, direction/auto-init config, next_word,
//                  read_address_or_count, underflow, transfer_address
//
// Optional feature: DMA_BASE_READBACK_EN adds base-register read strobes,
// served through the same pointer and mux below current-register reads.
//
// Multi-hot strobes/selects resolve to the lowest channel index. An
// address write strobe beats a coincident count write strobe; any write
// beats a read for byte-pointer movement while read data is still driven.
// CHANNELS must not exceed MAX_CHANNELS.
module dma_address_count_bank
  import dma_regs_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input logic                     clock,
  input logic                     reset,
  dma_address_count_bank_if.slave bus
);

  localparam int ADDR_BYTES  = byte_count(ADDR_WIDTH);
  localparam int COUNT_BYTES = byte_count(COUNT_WIDTH);
  localparam int BP_WIDTH    = bp_width(ADDR_WIDTH, COUNT_WIDTH);
  localparam int MAX_WIDTH   = (ADDR_WIDTH > COUNT_WIDTH) ? ADDR_WIDTH : COUNT_WIDTH;
  localparam int MAX_BYTES   = MAX_WIDTH / 8;

  logic [CHANNELS-1:0] wa_oh, wc_oh, ra_oh, rc_oh, sel_oh;

  logic [ADDR_WIDTH-1:0]  current_address [CHANNELS];
  logic [COUNT_WIDTH-1:0] current_count   [CHANNELS];
`ifdef DMA_BASE_READBACK_EN
  logic [ADDR_WIDTH-1:0]  base_address    [CHANNELS];
  logic [COUNT_WIDTH-1:0] base_count      [CHANNELS];
  logic [CHANNELS-1:0]    ba_oh, bc_oh;
`endif

  logic [BP_WIDTH-1:0]  bp, bp_next;
  logic                 bp_advance;
  int                   acc_bytes, rd_bytes;
  read_src_t            rd_src;
  logic [MAX_WIDTH-1:0] rd_word;
  logic [7:0]           read_byte;
  logic [ADDR_WIDTH-1:0]  sel_address;
  logic [COUNT_WIDTH-1:0] sel_count;

  // Strobe arbitration.
  assign wa_oh  = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.write_base_and_current_address)));
  assign wc_oh  = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.write_base_and_current_word_count)))
                & {CHANNELS{~|wa_oh}};
  assign ra_oh  = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.read_current_address)));
  assign rc_oh  = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.read_current_word_count)));
  assign sel_oh = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.transfer_register_select)));
`ifdef DMA_BASE_READBACK_EN
  assign ba_oh  = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.read_base_address)));
  assign bc_oh  = CHANNELS'(lowest_one_hot(MAX_CHANNELS'(bus.read_base_word_count)));
`endif

  // Channel register files.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
    dma_channel_regs #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH),
      .BP_WIDTH   (BP_WIDTH)
    ) u_regs (
      .clock          (clock),
      .reset          (reset),
      .master_clear   (bus.master_clear),
      .write_address  (wa_oh[ch]),
      .write_count    (wc_oh[ch]),
      .byte_pointer   (bp),
      .data           (bus.internal_data_bus),
      .initialize     (bus.initialize_current_register & sel_oh[ch]),
      .step           (bus.next_word & sel_oh[ch]),
      .decrement      (bus.decrement_address_config),
      .auto_initialize(bus.auto_initialize_config[ch]),
`ifdef DMA_BASE_READBACK_EN
      .base_address   (base_address[ch]),
      .base_count     (base_count[ch]),
`endif
      .current_address(current_address[ch]),
      .current_count  (current_count[ch])
    );
  end

  // Read source: current registers first, then base registers.
  always_comb begin
    rd_src = SRC_NONE;
    if (|ra_oh)      rd_src = SRC_CUR_ADDR;
    else if (|rc_oh) rd_src = SRC_CUR_COUNT;
`ifdef DMA_BASE_READBACK_EN
    else if (|ba_oh) rd_src = SRC_BASE_ADDR;
    else if (|bc_oh) rd_src = SRC_BASE_COUNT;
`endif
  end

  always_comb begin
    rd_word = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (rd_src == SRC_CUR_ADDR && ra_oh[ch])  rd_word = MAX_WIDTH'(current_address[ch]);
      if (rd_src == SRC_CUR_COUNT && rc_oh[ch]) rd_word = MAX_WIDTH'(current_count[ch]);
`ifdef DMA_BASE_READBACK_EN
      if (rd_src == SRC_BASE_ADDR && ba_oh[ch])  rd_word = MAX_WIDTH'(base_address[ch]);
      if (rd_src == SRC_BASE_COUNT && bc_oh[ch]) rd_word = MAX_WIDTH'(base_count[ch]);
`endif
    end
  end

  assign rd_bytes = (rd_src == SRC_CUR_ADDR || rd_src == SRC_BASE_ADDR) ? ADDR_BYTES : COUNT_BYTES;

  always_comb begin
    read_byte = 8'h00;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (rd_src != SRC_NONE && b < rd_bytes && int'(bp) == b) read_byte = rd_word[b*8 +: 8];
    end
  end

  assign bus.read_address_or_count = read_byte;

  // Byte pointer: one step per accessed edge, wrapping at the width of
  // whichever register that edge actually accessed.
  always_comb begin
    bp_advance = 1'b1;
    acc_bytes  = ADDR_BYTES;
    if (|wa_oh)                 acc_bytes  = ADDR_BYTES;
    else if (|wc_oh)            acc_bytes  = COUNT_BYTES;
    else if (rd_src == SRC_NONE) bp_advance = 1'b0;
    else                        acc_bytes  = rd_bytes;
    bp_next = (int'(bp) >= acc_bytes - 1) ? '0 : bp + BP_WIDTH'(1);
  end

  // clear_byte_pointer wins over the advance, but the access itself has
  // already used the old pointer this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                         bp <= '0;
    else if (bus.master_clear || bus.clear_byte_pointer) bp <= '0;
    else if (bp_advance)                               bp <= bp_next;
  end

  // Selected-channel view for the transfer engine.
  always_comb begin
    sel_address = '0;
    sel_count   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (sel_oh[ch]) begin
        sel_address = current_address[ch];
        sel_count   = current_count[ch];
      end
    end
  end

  assign bus.transfer_address = sel_address;
  assign bus.underflow = bus.next_word & ~bus.master_clear & (|sel_oh) & (sel_count == '0);

endmodule

// File: tb/tb_dma_address_count_bank.sv
// Self-checking bench for dma_address_count_bank: directed steps followed
// by a randomized section, all checked against a behavioural model that
// holds each channel's registers as plain integers.
module tb_dma_address_count_bank;

  localparam int CH = 4;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam int AB = AW / 8;
  localparam int CB = CW / 8;
  localparam longint AMOD = longint'(1) << AW;
  localparam longint CMOD = longint'(1) << CW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dma_address_count_bank_if #(.CHANNELS(CH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus();

  dma_address_count_bank #(.CHANNELS(CH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  longint         m_base_a [CH];
  longint         m_cur_a  [CH];
  longint         m_base_c [CH];
  longint         m_cur_c  [CH];
  int             m_bp;
  bit             m_dec;
  logic [CH-1:0]  m_auto;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int tests  = 0;
  int failed = 0;

  function automatic int lowest(input logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) begin
      m_base_a[i] = 0; m_cur_a[i] = 0; m_base_c[i] = 0; m_cur_c[i] = 0;
    end
    m_bp = 0;
  endfunction

  function automatic void m_advance(input int bytes);
    m_bp = (m_bp + 1 >= bytes) ? 0 : m_bp + 1;
  endfunction

  function automatic longint put_byte(input longint v, input int idx, input logic [7:0] d);
    return (v & ~(longint'(255) << (8 * idx))) | (longint'(d) << (8 * idx));
  endfunction

  function automatic logic [7:0] get_byte(input longint v, input int idx);
    return 8'((v >> (8 * idx)) & 255);
  endfunction

  function automatic bit m_underflow(input logic [CH-1:0] sel);
    int c;
    c = lowest(sel);
    return (c >= 0) && (m_cur_c[c] == 0);
  endfunction

  function automatic void m_step(input logic [CH-1:0] sel);
    int c;
    c = lowest(sel);
    if (c < 0) return;
    if (m_cur_c[c] == 0 && m_auto[c]) begin
      m_cur_a[c] = m_base_a[c];
      m_cur_c[c] = m_base_c[c];
    end else begin
      m_cur_a[c] = (m_cur_a[c] + (m_dec ? AMOD - 1 : 1)) % AMOD;
      m_cur_c[c] = (m_cur_c[c] + CMOD - 1) % CMOD;
    end
  endfunction

  function automatic longint m_taddr(input logic [CH-1:0] sel);
    int c;
    c = lowest(sel);
    return (c >= 0) ? m_cur_a[c] : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.internal_data_bus                 = '0;
    bus.write_base_and_current_address    = '0;
    bus.write_base_and_current_word_count = '0;
    bus.read_current_address              = '0;
    bus.read_current_word_count           = '0;
`ifdef DMA_BASE_READBACK_EN
    bus.read_base_address                 = '0;
    bus.read_base_word_count              = '0;
`endif
    bus.clear_byte_pointer                = 1'b0;
    bus.master_clear                      = 1'b0;
    bus.transfer_register_select          = '0;
    bus.initialize_current_register       = 1'b0;
    bus.next_word                         = 1'b0;
    bus.decrement_address_config          = m_dec;
    bus.auto_initialize_config            = m_auto;
  endtask

  task automatic cpu_write(input bit is_count, input logic [CH-1:0] strobe,
                           input logic [7:0] d, input bit clr);
    int c, bytes;
    idle();
    if (is_count) bus.write_base_and_current_word_count = strobe;
    else          bus.write_base_and_current_address    = strobe;
    bus.internal_data_bus  = d;
    bus.clear_byte_pointer = clr;
    tick();
    c = lowest(strobe);
    bytes = is_count ? CB : AB;
    if (c >= 0) begin
      if (m_bp < bytes) begin
        if (is_count) begin
          m_base_c[c] = put_byte(m_base_c[c], m_bp, d);
          m_cur_c[c]  = put_byte(m_cur_c[c], m_bp, d);
        end else begin
          m_base_a[c] = put_byte(m_base_a[c], m_bp, d);
          m_cur_a[c]  = put_byte(m_cur_a[c], m_bp, d);
        end
      end
      m_advance(bytes);
    end
    if (clr) m_bp = 0;
    idle();
  endtask

  task automatic cpu_read(input bit is_count, input logic [CH-1:0] strobe,
                          output logic [7:0] obs);
    idle();
    if (is_count) bus.read_current_word_count = strobe;
    else          bus.read_current_address    = strobe;
    #2;
    obs = bus.read_address_or_count;
    tick();
    if (lowest(strobe) >= 0) m_advance(is_count ? CB : AB);
    idle();
  endtask

  task automatic clear_bp();
    idle();
    bus.clear_byte_pointer = 1'b1;
    tick();
    m_bp = 0;
    idle();
  endtask

  task automatic write_word(input bit is_count, input int c, input logic [63:0] value);
    logic [CH-1:0] s;
    s = '0;
    s[c] = 1'b1;
    clear_bp();
    for (int b = 0; b < (is_count ? CB : AB); b++)
      cpu_write(is_count, s, get_byte(longint'(value), b), 1'b0);
  endtask

  task automatic read_word(input bit is_count, input int c, output logic [63:0] obs);
    logic [CH-1:0] s;
    logic [7:0] o8;
    s = '0;
    s[c] = 1'b1;
    obs = '0;
    clear_bp();
    for (int b = 0; b < (is_count ? CB : AB); b++) begin
      cpu_read(is_count, s, o8);
      obs[b*8 +: 8] = o8;
    end
  endtask

  task automatic pulse_next(input logic [CH-1:0] sel, output logic uf);
    idle();
    bus.transfer_register_select = sel;
    bus.next_word = 1'b1;
    #2;
    uf = bus.underflow;
    tick();
    m_step(sel);
    idle();
  endtask

  task automatic initialize(input logic [CH-1:0] sel);
    int c;
    idle();
    bus.transfer_register_select = sel;
    bus.initialize_current_register = 1'b1;
    tick();
    c = lowest(sel);
    if (c >= 0) begin
      m_cur_a[c] = m_base_a[c];
      m_cur_c[c] = m_base_c[c];
    end
    idle();
  endtask

  task automatic taddr(input logic [CH-1:0] sel, output logic [AW-1:0] obs);
    idle();
    bus.transfer_register_select = sel;
    #2;
    obs = bus.transfer_address;
    tick();
    idle();
  endtask

  task automatic mclear();
    idle();
    bus.master_clear = 1'b1;
    tick();
    m_reset();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_reset();
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [63:0]   w;
  logic [7:0]    b8;
  logic          uf;
  logic [AW-1:0] ta;
  int            op, rc, rk, nb;
  logic [CH-1:0] rsel, s1;
  logic [63:0]   rv;
  bit            exp_uf;

  initial begin
    m_dec  = 1'b0;
    m_auto = '0;
    m_reset();
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_read", bus.read_address_or_count, 8'h00);
    check("rst_underflow", bus.underflow, 1'b0);
    check("rst_taddr", bus.transfer_address, 16'h0000);
    bus.transfer_register_select = 4'b0001;
    bus.read_current_word_count  = 4'b0001;
    #1;
    check("rst_taddr_sel", bus.transfer_address, 16'h0000);
    check("rst_read_strobe", bus.read_address_or_count, 8'h00);
    idle();
    reset = 1'b0;
    tick();

    // Byte-serial write then read of ch1 address.
    cpu_write(1'b0, 4'b0010, 8'h12, 1'b0);
    cpu_write(1'b0, 4'b0010, 8'h34, 1'b0);
    cpu_read(1'b0, 4'b0010, b8);
    check("ch1_rd_lo", b8, 8'h12);
    cpu_read(1'b0, 4'b0010, b8);
    check("ch1_rd_hi", b8, 8'h34);
    pulse_next(4'b0010, uf);
    check("ch1_uf_zero_count", uf, 1'b1);
    taddr(4'b0010, ta);
    check("ch1_stepped", ta, 16'h3413);
    initialize(4'b0010);
    taddr(4'b0010, ta);
    check("ch1_base", ta, 16'h3412);

    // Increment across a byte boundary.
    m_dec = 1'b0;
    write_word(1'b0, 2, 64'h20FF);
    write_word(1'b1, 2, 64'h0200);
    pulse_next(4'b0100, uf);
    check("ch2_uf1", uf, 1'b0);
    pulse_next(4'b0100, uf);
    check("ch2_uf2", uf, 1'b0);
    read_word(1'b0, 2, w);
    check("ch2_addr", w, 64'h2101);
    read_word(1'b1, 2, w);
    check("ch2_count", w, 64'h01FE);
    taddr(4'b0100, ta);
    check("ch2_taddr", ta, 16'h2101);

    // Decrement with count wrap.
    m_dec = 1'b1;
    write_word(1'b0, 0, 64'h1100);
    write_word(1'b1, 0, 64'h0001);
    pulse_next(4'b0001, uf);
    check("ch0_uf1", uf, 1'b0);
    pulse_next(4'b0001, uf);
    check("ch0_uf2", uf, 1'b1);
    read_word(1'b0, 0, w);
    check("ch0_addr", w, 64'h10FE);
    read_word(1'b1, 0, w);
    check("ch0_count", w, 64'hFFFF);

    // Auto-initialize on underflow.
    m_dec  = 1'b0;
    m_auto = 4'b1000;
    write_word(1'b0, 3, 64'h3100);
    write_word(1'b1, 3, 64'h0000);
    pulse_next(4'b1000, uf);
    check("ch3_uf", uf, 1'b1);
    read_word(1'b0, 3, w);
    check("ch3_addr_reload", w, 64'h3100);
    read_word(1'b1, 3, w);
    check("ch3_count_reload", w, 64'h0000);
    m_auto = '0;

    // clear_byte_pointer between writes.
    do_reset();
    cpu_write(1'b0, 4'b0001, 8'hAB, 1'b0);
    clear_bp();
    cpu_write(1'b0, 4'b0001, 8'hCD, 1'b0);
    read_word(1'b0, 0, w);
    check("clr_bp_word", w, 64'h00CD);

    // clear_byte_pointer coincident with a write.
    cpu_write(1'b0, 4'b0001, 8'h55, 1'b1);
    cpu_write(1'b0, 4'b0001, 8'h66, 1'b0);
    cpu_write(1'b0, 4'b0001, 8'h77, 1'b0);
    read_word(1'b0, 0, w);
    check("clr_coincident", w, 64'h7766);

    // Multi-hot strobes and select.
    write_word(1'b0, 2, 64'h2101);
    clear_bp();
    cpu_write(1'b1, 4'b1010, 8'hA5, 1'b0);
    cpu_write(1'b1, 4'b1010, 8'h5A, 1'b0);
    read_word(1'b1, 1, w);
    check("multihot_wr_ch1", w, 64'h5AA5);
    read_word(1'b1, 3, w);
    check("multihot_wr_ch3", w, 64'h0000);
    clear_bp();
    cpu_read(1'b1, 4'b0110, b8);
    check("multihot_rd", b8, 8'hA5);
    taddr(4'b1100, ta);
    check("multihot_sel", ta, 16'h2101);

    // Simultaneous write and read: read data driven, write moves bp.
    clear_bp();
    bus.write_base_and_current_address = 4'b0001;
    bus.internal_data_bus              = 8'hEE;
    bus.read_current_word_count        = 4'b0010;
    #2;
    check("wr_rd_data", bus.read_address_or_count, 8'hA5);
    tick();
    m_cur_a[0]  = put_byte(m_cur_a[0], m_bp, 8'hEE);
    m_base_a[0] = put_byte(m_base_a[0], m_bp, 8'hEE);
    m_advance(AB);
    idle();
    cpu_write(1'b0, 4'b0001, 8'h44, 1'b0);
    read_word(1'b0, 0, w);
    check("wr_rd_addr", w, 64'h44EE);

    // No channel selected.
    pulse_next(4'b0000, uf);
    check("nosel_uf", uf, 1'b0);
    initialize(4'b0000);
    taddr(4'b0000, ta);
    check("nosel_taddr", ta, 16'h0000);

    // master_clear after loads, with bp left mid-register.
    cpu_write(1'b1, 4'b0001, 8'h99, 1'b0);
    mclear();
    cpu_write(1'b0, 4'b0001, 8'h5A, 1'b0);
    read_word(1'b0, 0, w);
    check("mclear_bp", w, 64'h005A);
    for (int c = 1; c < CH; c++) begin
      read_word(1'b0, c, w);
      check("mclear_addr", w, 64'h0);
      read_word(1'b1, c, w);
      check("mclear_count", w, 64'h0);
    end

    // Reset asserted in the middle of a byte-serial write.
    write_word(1'b0, 2, 64'hBEEF);
    cpu_write(1'b1, 4'b0100, 8'h77, 1'b0);
    bus.write_base_and_current_word_count = 4'b0100;
    bus.internal_data_bus = 8'h88;
    #1;
    reset = 1'b1;
    #1;
    idle();
    #1;
    reset = 1'b0;
    m_reset();
    tick();
    taddr(4'b0100, ta);
    check("midrst_taddr", ta, 16'h0000);
    cpu_write(1'b1, 4'b0100, 8'h3C, 1'b0);
    read_word(1'b1, 2, w);
    check("midrst_count", w, 64'h003C);

    // Randomized section against the model.
    for (int it = 0; it < 300; it++) begin
      op   = $urandom_range(0, 4);
      rc   = $urandom_range(0, CH - 1);
      rk   = $urandom_range(0, 1);
      rsel = CH'($urandom_range(0, (1 << CH) - 1));
      case (op)
        0: begin
          rv = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 3))
                                           : 64'($urandom_range(0, 65535));
          write_word(rk[0], rc, rv);
        end
        1: begin
          nb = rk[0] ? CB : AB;
          s1 = '0;
          s1[rc] = 1'b1;
          clear_bp();
          for (int b = 0; b < nb; b++)
            exp_q.push_back(get_byte(rk[0] ? m_cur_c[rc] : m_cur_a[rc], b));
          for (int b = 0; b < nb; b++) begin
            cpu_read(rk[0], s1, b8);
            check("rnd_read", b8, exp_q.pop_front());
          end
        end
        2: begin
          m_dec  = $urandom_range(0, 1);
          m_auto = CH'($urandom_range(0, (1 << CH) - 1));
          exp_uf = m_underflow(rsel);
          pulse_next(rsel, uf);
          check("rnd_underflow", uf, exp_uf);
        end
        3: initialize(rsel);
        default: begin
          taddr(rsel, ta);
          check("rnd_taddr", ta, m_taddr(rsel));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dma_address_count_bank.md
# dma_address_count_bank

Parametrised base/current address and word-count register bank for the KF8237 DMA datapath, generalised to CHANNELS channels with independent address and count widths. CPU accesses go byte-serially through a shared byte pointer. A per-transfer `next_word` pulse steps the selected channel's current address up or down and decrements its count. Count underflow either wraps or auto-reloads from the base registers. The bank sits between the bus/command decoder and the transfer timing state machine.

## Interface
- CHANNELS, 4: number of DMA channels; minimum 1.
- ADDR_WIDTH, 16: address register width; multiple of 8.
- COUNT_WIDTH, 16: word-count register width; multiple of 8.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- internal_data_bus  in  8  CPU write data.
- read_address_or_count  out  8  CPU read data.
- write_base_and_current_address  in  CHANNELS  one-hot write strobe, address registers.
- write_base_and_current_word_count  in  CHANNELS  one-hot write strobe, count registers.
- read_current_address  in  CHANNELS  one-hot read strobe, current address.
- read_current_word_count  in  CHANNELS  one-hot read strobe, current count.
- clear_byte_pointer  in  1  forces the byte pointer to 0.
- master_clear  in  1  synchronous clear of all state.
- transfer_register_select  in  CHANNELS  one-hot active transfer channel.
- initialize_current_register  in  1  reloads current from base for the selected channel.
- decrement_address_config  in  1  1 = address decrements, 0 = increments.
- auto_initialize_config  in  CHANNELS  per-channel auto-init enable.
- next_word  in  1  one-cycle pulse: one word transferred.
- underflow  out  1  count of the selected channel wraps on this next_word.
- transfer_address  out  ADDR_WIDTH  current address of the selected channel.

## Operation
- Per channel: base_address, current_address (ADDR_WIDTH); base_count, current_count (COUNT_WIDTH).
- Byte pointer `bp`:
  - Shared across all channels and strobes.
  - Width is clog2 of max(ADDR_WIDTH, COUNT_WIDTH)/8.
  - Selects byte `bp` (LSB first).
- Write strobe sampled high at a clock edge:
  - Byte `bp` of both base and current of the strobed channel is loaded from internal_data_bus.
  - bp advances. It wraps to 0 after the last byte of the accessed register width.
- Read strobe high: read_address_or_count = byte `bp` of the strobed current register, combinationally. bp advances at that edge with the same wrap rule.
- No read strobe: read_address_or_count = 8'h00.
- Multi-hot strobe or select: lowest index wins. Simultaneous write and read strobes: write wins, read data still driven.
- next_word with a selected channel:
  - current_address ±1, modulo 2^ADDR_WIDTH.
  - current_count −1, modulo 2^COUNT_WIDTH.
- underflow = next_word & (selected current_count == 0), combinational.
- On underflow with auto_initialize_config[ch] = 1: current_address and current_count reload from base instead of stepping.
- initialize_current_register: selected channel current ← base; no effect on bp.
- No channel selected: next_word and initialize are ignored; transfer_address = 0.
- Priority per channel, highest first: master_clear > CPU write > initialize_current_register > next_word.
- clear_byte_pointer coincident with a strobe: the access uses the current bp, then bp is forced to 0.

## Timing
- Reset and master_clear: all registers 0, bp = 0; read_address_or_count = 0, underflow = 0, transfer_address = 0.
- Register updates take effect at the sampling edge. transfer_address reflects a step one cycle after next_word.
- read_address_or_count, underflow, transfer_address are combinational from registered state and inputs; 0-cycle latency.
- Reset mid-operation: immediate clear, no partial byte retained.

## Configuration
- DMA_BASE_READBACK_EN defined:
  - Adds inputs read_base_address and read_base_word_count, each CHANNELS wide.
  - They read base registers through the same bp and mux, at lower priority than current-register reads.
- Not defined: the inputs do not exist; base registers are write-only.

## Structure
- Package dma_regs_pkg holds:
  - byte-count constants derived from the widths;
  - the bp width function;
  - a priority-select function (lowest-index one-hot).
- Sub-module dma_channel_regs: one channel's four registers, write and step logic, instantiated CHANNELS times via generate. The byte pointer and read mux live in the top.

## Test plan
- Write ch1 address 8'h12 then 8'h34 -> two reads of ch1 return 8'h12, 8'h34; base = current = 16'h3412.
- Select ch2, address 16'h20FF, count 16'h0200, increment; two next_word pulses -> address 16'h2101, count 16'h01FE, underflow never high.
- Decrement mode, address 16'h1100, count 16'h0001; two next_word pulses -> address 16'h10FE; underflow high only on the second pulse; count 16'hFFFF.
- Auto-init on ch3, base address 16'h3100, count 16'h0000; next_word -> underflow = 1, current reloads to 16'h3100 / 16'h0000.
- Write 8'hAB, pulse clear_byte_pointer, write 8'hCD -> low byte 8'hCD, high byte 0 after reset.
- master_clear after arbitrary loads -> every read returns 8'h00 and bp = 0; reset asserted mid-write -> same.
